// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-access stage: one load/store per Start over a req/ack
//            port, with lane steering, load extension and error detection.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic        MemWrite,
  input  logic [2:0]  LoadStoreType,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic [1:0]  Error,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemByteEn,
  input  logic [31:0] MemRData,
  input  logic        MemAck
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  lo_q, lo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        mwe_q, mwe_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic        illegal_w;
  logic        misaligned_w;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] shifted_w;
  logic [31:0] load_w;
  logic [7:0]  cnt_inc_w;

  // Request decode from the live inputs; only consumed when Start is taken in IDLE.
  always_comb begin
    illegal_w    = 1'b0;
    misaligned_w = 1'b0;
    be_w         = 4'b0000;
    wdata_w      = '0;
    case (LoadStoreType)
      3'b000, 3'b100: begin
        be_w    = 4'b0001 << ALUResult[1:0];
        wdata_w = {4{WriteData[7:0]}};
      end
      3'b001, 3'b101: begin
        be_w         = 4'b0011 << {ALUResult[1], 1'b0};
        wdata_w      = {2{WriteData[15:0]}};
        misaligned_w = ALUResult[0];
      end
      3'b010: begin
        be_w         = 4'b1111;
        wdata_w      = WriteData;
        misaligned_w = |ALUResult[1:0];
      end
      default: illegal_w = 1'b1;
    endcase
    if (MemWrite && LoadStoreType[2]) begin
      illegal_w = 1'b1;
    end
    if (!MemWrite || illegal_w) begin
      wdata_w = '0;
    end
    if (illegal_w) begin
      be_w = 4'b0000;
    end
  end

  // Halfword accesses only ever have lo_q of 00 or 10, so one shifter serves B and H.
  always_comb begin
    shifted_w = MemRData >> {lo_q, 3'b000};
    case (type_q)
      3'b000:  load_w = {{24{shifted_w[7]}}, shifted_w[7:0]};
      3'b001:  load_w = {{16{shifted_w[15]}}, shifted_w[15:0]};
      3'b010:  load_w = shifted_w;
      3'b100:  load_w = {24'h000000, shifted_w[7:0]};
      3'b101:  load_w = {16'h0000, shifted_w[15:0]};
      default: load_w = '0;
    endcase
  end

  assign cnt_inc_w = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    type_d  = type_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    mwe_d   = mwe_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          we_d    = MemWrite;
          type_d  = LoadStoreType;
          lo_d    = ALUResult[1:0];
          addr_d  = {ALUResult[31:2], 2'b00};
          wdata_d = wdata_w;
          be_d    = be_w;
          cnt_d   = '0;
          if (illegal_w) begin
            err_d   = 2'b11;
            rdata_d = '0;
            state_d = RESP;
          end else if (misaligned_w) begin
            err_d   = 2'b01;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            req_d   = 1'b1;
            mwe_d   = MemWrite;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_inc_w;
        // An ack on the final counted cycle still completes successfully.
        if (MemAck) begin
          req_d   = 1'b0;
          mwe_d   = 1'b0;
          err_d   = 2'b00;
          rdata_d = we_q ? 32'h0 : load_w;
          state_d = RESP;
        end else if (cnt_inc_w == TIMEOUT_C) begin
          req_d   = 1'b0;
          mwe_d   = 1'b0;
          err_d   = 2'b10;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      type_q  <= 3'b000;
      lo_q    <= 2'b00;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      mwe_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      rdata_q <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      type_q  <= type_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      mwe_q   <= mwe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == RESP);
  assign ReadData  = rdata_q;
  assign Error     = err_q;
  assign MemReq    = req_q;
  assign MemWe     = mwe_q;
  assign MemAddr   = addr_q;
  assign MemWData  = wdata_q;
  assign MemByteEn = be_q;

endmodule
`default_nettype wire
